sd_rx_pack_fifo: RTL and testbench

- Single-clock receive FIFO for the SD data path.
- Packs DIN_W-bit data-line beats (1, 4 or 8 lanes) into WORD_W-bit words, with endianness selected by parameter.
- Stores each word with a valid-beat count, so a block tail shorter than one word can be flushed without losing data.
- Sits between the SD data serialiser and the host/DMA read side, and reports level, almost-full and sticky overflow.

---
 rtl/sd_rx_fifo_pkg.sv | 33 +++
 rtl/sd_rx_pack_fifo_packer.sv | 71 +++++++
 rtl/sd_rx_pack_fifo.sv | 169 ++++++++++++++++
 tb/tb_sd_rx_pack_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_rx_fifo_pkg.sv
// Shared helpers for the SD receive pack FIFO: configuration checks and
// width helpers used by the packer and the FIFO top level.
package sd_rx_fifo_pkg;

    // Beat widths the SD data path can present (1, 4 or 8 data lanes).
    function automatic bit din_w_legal(input int din_w);
        return (din_w == 32'sd1) || (din_w == 32'sd4) || (din_w == 32'sd8);
    endfunction

    // Number of beats that make up one stored word.
    function automatic int beats_per_word(input int word_w, input int din_w);
        return word_w / din_w;
    endfunction

    // Width of the per-entry valid-beat count (must be able to hold N).
    function automatic int cnt_width(input int word_w, input int din_w);
        return $clog2(word_w / din_w) + 32'sd1;
    endfunction

    // Pointer width: RAM address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // Whole parameter set is usable.
    function automatic bit cfg_ok(input int din_w, input int word_w, input int depth);
        return din_w_legal(din_w)
            && ((word_w % din_w) == 32'sd0)
            && (depth >= 32'sd2)
            && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/sd_rx_pack_fifo_packer.sv
// Beat packer: assembles DIN_W-bit beats into WORD_W-bit words. A push is
// raised in the same cycle as the completing beat (or a flush) so the
// pushed word already contains the current beat.
module sd_rx_packer
    import sd_rx_fifo_pkg::*;
#(
    parameter int DIN_W   = 4,
    parameter int WORD_W  = 32,
    parameter int BIG_END = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DIN_W-1:0]                      d_i,
    input  logic                                  wr_i,
    input  logic                                  flush_i,
    output logic                                  push_o,
    output logic [WORD_W-1:0]                     word_o,
    output logic [cnt_width(WORD_W, DIN_W)-1:0]   cnt_o
);

    localparam int N  = beats_per_word(WORD_W, DIN_W);
    localparam int CW = cnt_width(WORD_W, DIN_W);

    logic [CW-1:0]     bc_q, bc_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] word_s;
    logic [CW-1:0]     cnt_s;
    logic              last_s;
    logic              push_s;

    // Merge the current beat into its slot, decide on a push, advance bc.
    always_comb begin
        word_s = acc_q;
        for (int k = 0; k < N; k++) begin
            word_s[((BIG_END != 0) ? (WORD_W - (k + 1) * DIN_W) : (k * DIN_W)) +: DIN_W] =
                (wr_i && (bc_q == CW'(k))) ? d_i
                : acc_q[((BIG_END != 0) ? (WORD_W - (k + 1) * DIN_W) : (k * DIN_W)) +: DIN_W];
        end
        if (wr_i) begin
            cnt_s = bc_q + CW'(1);
        end else begin
            cnt_s = bc_q;
        end
        last_s = wr_i && (bc_q == CW'(N - 1));
        push_s = last_s || (flush_i && (cnt_s != '0));
        if (push_s) begin
            // Unfilled slots of the next word must read back as zero.
            bc_d  = '0;
            acc_d = '0;
        end else begin
            bc_d  = cnt_s;
            acc_d = word_s;
        end
    end

    // Beat counter and partial-word accumulator; reset drops a partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_q  <= '0;
            acc_q <= '0;
        end else begin
            bc_q  <= bc_d;
            acc_q <= acc_d;
        end
    end

    assign push_o = push_s;
    assign word_o = word_s;
    assign cnt_o  = cnt_s;

endmodule

// File: rtl/sd_rx_pack_fifo.sv
// SD receive pack FIFO: packer in front of a DEPTH-entry RAM FIFO storing
// {word, valid-beat count}. Level and flags are registered.
// Build option: define SD_RX_FIFO_FWFT_EN for first-word fall-through reads;
// otherwise rd loads q/q_cnt on the next edge and pulses q_vld.
module sd_rx_pack_fifo
    import sd_rx_fifo_pkg::*;
#(
    parameter int DIN_W     = 4,
    parameter int WORD_W    = 32,
    parameter int DEPTH     = 8,
    parameter int BIG_END   = 1,
    parameter int AFULL_THR = DEPTH - 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DIN_W-1:0]                      d,
    input  logic                                  wr,
    input  logic                                  flush,
    input  logic                                  rd,
    output logic [WORD_W-1:0]                     q,
    output logic [cnt_width(WORD_W, DIN_W)-1:0]   q_cnt,
    output logic                                  q_vld,
    output logic                                  full,
    output logic                                  empty,
    output logic                                  afull,
    output logic [ptr_width(DEPTH)-1:0]           level,
    output logic                                  ovf,
    input  logic                                  ovf_clr
);

    localparam int CW = cnt_width(WORD_W, DIN_W);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    if (!cfg_ok(DIN_W, WORD_W, DEPTH)) begin : g_cfg_err
        $error("sd_rx_pack_fifo: illegal DIN_W/WORD_W/DEPTH combination");
    end

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [CW-1:0]     cnt;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            head_s;
    logic              push_s;
    logic [WORD_W-1:0] word_s;
    logic [CW-1:0]     cnt_s;
    logic              pop_s, accept_s, drop_s;
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d;
    logic              ovf_q, ovf_d;

    sd_rx_packer #(
        .DIN_W   (DIN_W),
        .WORD_W  (WORD_W),
        .BIG_END (BIG_END)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (d),
        .wr_i    (wr),
        .flush_i (flush),
        .push_o  (push_s),
        .word_o  (word_s),
        .cnt_o   (cnt_s)
    );

    // Push/pop arbitration, next pointers, level and flags.
    always_comb begin
        pop_s    = rd && !empty_q;
        // A pop in the same cycle frees the slot even when full.
        accept_s = push_s && (!full_q || pop_s);
        drop_s   = push_s && !accept_s;
        if (accept_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({accept_s, pop_s})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == PW'(DEPTH));
        empty_d = (level_d == '0);
        afull_d = (level_d >= PW'(AFULL_THR));
        // A drop wins over a clear in the same cycle.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pointer, level and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wptr_q[AW-1:0]] <= '{data: word_s, cnt: cnt_s};
        end
    end

    assign head_s = mem_q[rptr_q[AW-1:0]];

`ifdef SD_RX_FIFO_FWFT_EN
    assign q     = head_s.data;
    assign q_cnt = head_s.cnt;
    assign q_vld = !empty_q;
`else
    logic [WORD_W-1:0] q_data_q;
    logic [CW-1:0]     q_cnt_q;
    logic              q_vld_q;

    // Registered read port: load on pop, hold otherwise, one-cycle valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data_q <= '0;
            q_cnt_q  <= '0;
            q_vld_q  <= 1'b0;
        end else begin
            q_vld_q <= pop_s;
            if (pop_s) begin
                q_data_q <= head_s.data;
                q_cnt_q  <= head_s.cnt;
            end
        end
    end

    assign q     = q_data_q;
    assign q_cnt = q_cnt_q;
    assign q_vld = q_vld_q;
`endif

    assign full  = full_q;
    assign empty = empty_q;
    assign afull = afull_q;
    assign level = level_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_sd_rx_pack_fifo.sv
// Bench for sd_rx_pack_fifo: a big-endian and a little-endian instance share
// all inputs; a queue-based reference model checks every cycle, a vector
// table checks the nibble/flush cases, plus overflow, wrap, reset and
// random sequences.
module tb_sd_rx_pack_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  d;
    logic        wr, flush, rd, ovf_clr;

    logic [31:0] q_be, q_le;
    logic [3:0]  qc_be, qc_le;
    logic        qv_be, qv_le, fu_be, fu_le, em_be, em_le, af_be, af_le, ov_be, ov_le;
    logic [3:0]  lv_be, lv_le;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sd_rx_pack_fifo #(.DIN_W(4), .WORD_W(32), .DEPTH(8), .BIG_END(1)) u_be (
        .clk(clk), .rst_n(rst_n), .d(d), .wr(wr), .flush(flush), .rd(rd),
        .q(q_be), .q_cnt(qc_be), .q_vld(qv_be), .full(fu_be), .empty(em_be),
        .afull(af_be), .level(lv_be), .ovf(ov_be), .ovf_clr(ovf_clr));

    sd_rx_pack_fifo #(.DIN_W(4), .WORD_W(32), .DEPTH(8), .BIG_END(0)) u_le (
        .clk(clk), .rst_n(rst_n), .d(d), .wr(wr), .flush(flush), .rd(rd),
        .q(q_le), .q_cnt(qc_le), .q_vld(qv_le), .full(fu_le), .empty(em_le),
        .afull(af_le), .level(lv_le), .ovf(ov_le), .ovf_clr(ovf_clr));

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] be;
        logic [31:0] le;
        logic [3:0]  cnt;
    } ment_t;

    ment_t      mq[$];
    logic [3:0] mbeats[$];
    logic       movf;
    logic [31:0] eq_be, eq_le;
    logic [3:0]  ecnt;
    logic        evld;
    logic [31:0] pre_be, pre_le;
    logic [3:0]  pre_cnt;

    task automatic model_reset();
        mq.delete();
        mbeats.delete();
        movf  = 1'b0;
        eq_be = 32'h0;
        eq_le = 32'h0;
        ecnt  = 4'h0;
        evld  = 1'b0;
    endtask

    task automatic model_update(input logic w, input logic [3:0] dd, input logic fl,
                                input logic r, input logic oc);
        ment_t e, popped;
        logic  pop;
        logic  dropped;
        pop     = r && (mq.size() > 0);
        dropped = 1'b0;
        popped  = '{be: 32'h0, le: 32'h0, cnt: 4'h0};
        if (pop) popped = mq.pop_front();
        if (w) mbeats.push_back(dd);
        if (mbeats.size() == 8 || (fl && mbeats.size() > 0)) begin
            e.be  = 32'h0;
            e.le  = 32'h0;
            e.cnt = 4'(mbeats.size());
            for (int i = 0; i < mbeats.size(); i++) begin
                e.be = e.be | (32'(mbeats[i]) << (28 - 4 * i));
                e.le = e.le | (32'(mbeats[i]) << (4 * i));
            end
            mbeats.delete();
            if (mq.size() < 8) mq.push_back(e);
            else dropped = 1'b1;
        end
        if (dropped) movf = 1'b1;
        else if (oc) movf = 1'b0;
`ifndef SD_RX_FIFO_FWFT_EN
        evld = pop;
        if (pop) begin
            eq_be = popped.be;
            eq_le = popped.le;
            ecnt  = popped.cnt;
        end
`endif
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input bit is_le, input logic [31:0] qq,
                             input logic [3:0] qc, input logic qv, input logic fu,
                             input logic em, input logic af, input logic [3:0] lv,
                             input logic ov);
        int sz;
        sz = mq.size();
        chk({tag, ".level"}, 32'(lv), 32'(sz));
        chk({tag, ".full"},  32'(fu), 32'(sz == 8));
        chk({tag, ".empty"}, 32'(em), 32'(sz == 0));
        chk({tag, ".afull"}, 32'(af), 32'(sz >= 6));
        chk({tag, ".ovf"},   32'(ov), 32'(movf));
`ifdef SD_RX_FIFO_FWFT_EN
        chk({tag, ".q_vld"}, 32'(qv), 32'(sz != 0));
        if (sz != 0) begin
            chk({tag, ".q"},     qq, is_le ? mq[0].le : mq[0].be);
            chk({tag, ".q_cnt"}, 32'(qc), 32'(mq[0].cnt));
        end
`else
        chk({tag, ".q_vld"}, 32'(qv), 32'(evld));
        chk({tag, ".q"},     qq, is_le ? eq_le : eq_be);
        chk({tag, ".q_cnt"}, 32'(qc), 32'(ecnt));
`endif
    endtask

    task automatic check_all();
        check_dut("be", 1'b0, q_be, qc_be, qv_be, fu_be, em_be, af_be, lv_be, ov_be);
        check_dut("le", 1'b1, q_le, qc_le, qv_le, fu_le, em_le, af_le, lv_le, ov_le);
    endtask

    // One clock of stimulus; inputs change at posedge+1, outputs checked there too.
    task automatic step(input logic w, input logic [3:0] dd, input logic fl,
                        input logic r, input logic oc);
        wr = w; d = dd; flush = fl; rd = r; ovf_clr = oc;
        pre_be = q_be; pre_le = q_le; pre_cnt = qc_be;
        @(posedge clk);
        #1;
        model_update(w, dd, fl, r, oc);
        check_all();
        wr = 1'b0; flush = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
    endtask

    // Eight nibbles of w, most significant first; rd/ovf_clr options.
    task automatic send_word(input logic [31:0] w, input logic rd_all,
                             input logic rd_last, input logic oc_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, w[31 - 4 * i -: 4], 1'b0, rd_all || (rd_last && i == 7),
                 oc_last && i == 7);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        w;
        logic [3:0]  dd;
        logic        fl;
        logic        r;
        logic [3:0]  exp_level;
        logic [31:0] exp_be;
        logic [31:0] exp_le;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t tbl[24];

    initial begin
        logic [31:0] act_be, act_le;
        logic [3:0]  act_cnt;

        rst_n = 1'b0; d = 4'h0; wr = 1'b0; flush = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
        model_reset();

        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 4'(i + 1), 1'b0, 1'b0, (i == 7) ? 4'd1 : 4'd0, 32'h0, 32'h0, 4'h0};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 32'h12345678, 32'h87654321, 4'd8};
        tbl[9]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0};
        tbl[10] = '{1'b1, 4'hB, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0};
        tbl[11] = '{1'b1, 4'hC, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'd1, 32'h0, 32'h0, 4'h0};
        tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'd1, 32'h0, 32'h0, 4'h0};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 32'hABC00000, 32'h00000CBA, 4'd3};
        for (int i = 0; i < 7; i++)
            tbl[15 + i] = '{1'b1, 4'(i + 1), 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'h0};
        tbl[22] = '{1'b1, 4'h8, 1'b1, 1'b0, 4'd1, 32'h0, 32'h0, 4'h0};
        tbl[23] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 32'h12345678, 32'h87654321, 4'd8};

        // Reset state
        #12;
        check_all();
        chk("rst.empty", 32'(em_be), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven nibble assembly and flush cases
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].w, tbl[i].dd, tbl[i].fl, tbl[i].r, 1'b0);
            chk($sformatf("tbl%0d.level", i), 32'(lv_be), 32'(tbl[i].exp_level));
            if (tbl[i].r) begin
`ifdef SD_RX_FIFO_FWFT_EN
                act_be = pre_be; act_le = pre_le; act_cnt = pre_cnt;
`else
                act_be = q_be; act_le = q_le; act_cnt = qc_be;
`endif
                chk($sformatf("tbl%0d.q_be", i), act_be, tbl[i].exp_be);
                chk($sformatf("tbl%0d.q_le", i), act_le, tbl[i].exp_le);
                chk($sformatf("tbl%0d.q_cnt", i), 32'(act_cnt), 32'(tbl[i].exp_cnt));
            end
        end

        // Overflow: nine words, no reads
        for (int k = 1; k <= 9; k++) send_word(32'h1111_1111 * 32'(k), 1'b0, 1'b0, 1'b0);
        chk("ovf.level", 32'(lv_be), 32'd8);
        chk("ovf.full", 32'(fu_be), 32'd1);
        chk("ovf.flag", 32'(ov_be), 32'd1);
        // Clear in the same cycle as another drop: flag stays set
        send_word(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        chk("ovf.clr_vs_drop", 32'(ov_be), 32'd1);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("ovf.clr", 32'(ov_be), 32'd0);
        // At full, complete a word together with a read: accepted
        send_word(32'h5A5A_C3C3, 1'b0, 1'b1, 1'b0);
        chk("full_rw.level", 32'(lv_be), 32'd8);
        chk("full_rw.ovf", 32'(ov_be), 32'd0);
        for (int k = 0; k < 8; k++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        // rd on empty: nothing happens
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("rd_empty.q_vld", 32'(qv_be), 32'd0);
        chk("rd_empty.level", 32'(lv_be), 32'd0);

        // Wrap and ordering: 20 words with rd held high
        for (int k = 0; k < 20; k++) send_word(32'(k), 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("wrap.empty", 32'(em_be), 32'd1);

        // Mid-word reset after five beats
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        chk("rst_mid.level", 32'(lv_be), 32'd1);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
`ifndef SD_RX_FIFO_FWFT_EN
        chk("rst_mid.q", q_be, 32'hCAFE_F00D);
`endif

        // Randomised traffic: fill-biased phase then drain-biased phase
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 15) == 0,
                 (i < 750) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
                 $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
